modulo_corrector_secded: RTL and testbench

MODULO_CORRECTOR_SECDED -- requirements
Module: modulo_corrector_secded

---
 rtl/modulo_corrector_secded_if.sv | 32 +++
 rtl/modulo_corrector_secded.sv | 140 ++++++++++++++
 tb/tb_modulo_corrector_secded.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/modulo_corrector_secded_if.sv
// SECDED corrector stream bundle: codeword in, corrected data and flags out.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; slave is the corrector, master the neighbour.
interface modulo_corrector_secded_if #(
  parameter int DATA_W = 4
);
  localparam int P_W  = (DATA_W == 4) ? 3 : (DATA_W == 11) ? 4 : 5;
  localparam int CW_W = DATA_W + P_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_cw;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [P_W-1:0]    out_sindrome;
  logic              out_error;
  logic              out_corregido;
  logic              out_doble;

  modport slave (
    input  in_valid, in_cw, out_ready,
    output in_ready, out_valid, out_data, out_sindrome,
           out_error, out_corregido, out_doble
  );

  modport master (
    output in_valid, in_cw, out_ready,
    input  in_ready, out_valid, out_data, out_sindrome,
           out_error, out_corregido, out_doble
  );
endinterface

// File: rtl/modulo_corrector_secded.sv
// Extended-Hamming SECDED corrector with saturating corrected/double-error counters.
// Latency: 2 cycles input handshake to out_valid; one word per cycle sustained.
// Backpressure: out_ready low freezes S2 and S1; in_ready drops only when both stages hold words.
module modulo_corrector_secded #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  modulo_corrector_secded_if.slave bus,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      cnt_simple,
  output logic [CNT_W-1:0]      cnt_doble
);
  localparam int P_W  = (DATA_W == 4) ? 3 : (DATA_W == 11) ? 4 : 5;
  localparam int CW_W = DATA_W + P_W + 1;

  // Stage 1: raw codeword plus its syndrome and overall parity
  logic              r_s1_vld;
  logic [CW_W-1:0]   r_s1_cw;
  logic [P_W-1:0]    r_s1_syn;
  logic              r_s1_gp;

  // Stage 2: corrected data and classification, drives the outputs directly
  logic              r_s2_vld;
  logic [DATA_W-1:0] r_s2_data;
  logic [P_W-1:0]    r_s2_syn;
  logic              r_s2_corr;
  logic              r_s2_doble;

  logic              w_s1_adv;
  logic              w_in_hs;
  logic              w_out_hs;
  logic [P_W-1:0]    w_syn;
  logic              w_gp;
  logic [CW_W-1:0]   w_flip;
  logic [CW_W-1:0]   w_cw_fix;
  logic [DATA_W-1:0] w_data;
  logic              w_corr;
  logic              w_doble;

  // S1 may move forward whenever S2 is empty or being drained this cycle
  assign w_s1_adv      = !r_s2_vld || bus.out_ready;
  assign bus.in_ready  = !r_s1_vld || w_s1_adv;
  assign w_in_hs       = bus.in_valid && bus.in_ready;
  assign w_out_hs      = r_s2_vld && bus.out_ready;

  assign bus.out_valid     = r_s2_vld;
  assign bus.out_data      = r_s2_data;
  assign bus.out_sindrome  = r_s2_syn;
  assign bus.out_corregido = r_s2_corr;
  assign bus.out_doble     = r_s2_doble;
  assign bus.out_error     = r_s2_corr || r_s2_doble;

  // Syndrome bit j covers every Hamming position (index+1) with bit j set
  always_comb begin
    w_syn = '0;
    for (int k = 0; k < CW_W - 1; k++) begin
      for (int j = 0; j < P_W; j++) begin
        if ((((k + 1) >> j) & 1) == 1) w_syn[j] = w_syn[j] ^ bus.in_cw[k];
      end
    end
  end

  assign w_gp = ^bus.in_cw;

  // Single error inside the Hamming part: syndrome names the position, flip index syn-1
  always_comb begin
    w_flip = '0;
    if ((r_s1_syn != '0) && r_s1_gp) w_flip[r_s1_syn - P_W'(1)] = 1'b1;
  end

  assign w_cw_fix = r_s1_cw ^ w_flip;
  // gp=1 means an odd error count: either a Hamming bit (fixed above) or the parity bit itself
  assign w_corr   = r_s1_gp;
  assign w_doble  = (r_s1_syn != '0) && !r_s1_gp;

  // Gather data bits from non-power-of-two positions, lowest position first
  always_comb begin
    int d;
    w_data = '0;
    d      = 0;
    for (int k = 0; k < CW_W - 1; k++) begin
      if ((((k + 1) & k)) != 0) begin
        w_data[d] = w_cw_fix[k];
        d         = d + 1;
      end
    end
  end

  // Stage 1 register: accepts a new word whenever in_ready is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_cw  <= '0;
      r_s1_syn <= '0;
      r_s1_gp  <= 1'b0;
    end else begin
      if (bus.in_ready) r_s1_vld <= bus.in_valid;
      if (w_in_hs) begin
        r_s1_cw  <= bus.in_cw;
        r_s1_syn <= w_syn;
        r_s1_gp  <= w_gp;
      end
    end
  end

  // Stage 2 register: only reloads when S1 advances, so outputs hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld   <= 1'b0;
      r_s2_data  <= '0;
      r_s2_syn   <= '0;
      r_s2_corr  <= 1'b0;
      r_s2_doble <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data  <= w_data;
        r_s2_syn   <= r_s1_syn;
        r_s2_corr  <= w_corr;
        r_s2_doble <= w_doble;
      end
    end
  end

  // Saturating event counters, bumped on output handshake; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_simple <= '0;
      cnt_doble  <= '0;
    end else if (clr_cnt) begin
      cnt_simple <= '0;
      cnt_doble  <= '0;
    end else if (w_out_hs) begin
      if (r_s2_corr && (cnt_simple != {CNT_W{1'b1}})) cnt_simple <= cnt_simple + CNT_W'(1);
      if (r_s2_doble && (cnt_doble != {CNT_W{1'b1}})) cnt_doble <= cnt_doble + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_modulo_corrector_secded.sv
// Directed bench for the SECDED corrector: two instances (CNT_W=8 and CNT_W=2).
// Latency: expects outputs two cycles after the input handshake.
// Backpressure: exercises out_ready low with three queued words.
module tb_modulo_corrector_secded;
  logic       clk;
  logic       rst_n;
  logic       clr_a;
  logic       clr_b;
  logic [7:0] cnt_simple_a;
  logic [7:0] cnt_doble_a;
  logic [1:0] cnt_simple_b;
  logic [1:0] cnt_doble_b;
  int         checks;
  int         errors;

  modulo_corrector_secded_if #(.DATA_W(4)) if_a ();
  modulo_corrector_secded_if #(.DATA_W(4)) if_b ();

  modulo_corrector_secded #(.DATA_W(4), .CNT_W(8)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (if_a.slave),
    .clr_cnt    (clr_a),
    .cnt_simple (cnt_simple_a),
    .cnt_doble  (cnt_doble_a)
  );

  modulo_corrector_secded #(.DATA_W(4), .CNT_W(2)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (if_b.slave),
    .clr_cnt    (clr_b),
    .cnt_simple (cnt_simple_b),
    .cnt_doble  (cnt_doble_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns at the falling edge where the word is on the outputs.
  task automatic apply_a(input logic [7:0] cw, input string tag);
    if_a.in_valid = 1'b1;
    if_a.in_cw    = cw;
    @(posedge clk);
    #1 if_a.in_valid = 1'b0;
    chk({tag, "_lat1"}, {31'd0, if_a.out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, {31'd0, if_a.out_valid}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr_a  = 1'b0;
    clr_b  = 1'b0;
    if_a.in_valid  = 1'b0;
    if_a.in_cw     = '0;
    if_a.out_ready = 1'b1;
    if_b.in_valid  = 1'b0;
    if_b.in_cw     = '0;
    if_b.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, if_a.out_valid}, 32'd0);
    chk("rst_out_data", {28'd0, if_a.out_data}, 32'd0);
    chk("rst_sindrome", {29'd0, if_a.out_sindrome}, 32'd0);
    chk("rst_flags", {29'd0, if_a.out_error, if_a.out_corregido, if_a.out_doble}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_simple_a, cnt_doble_a}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_in_ready", {31'd0, if_a.in_ready}, 32'd1);

    // Clean codeword
    apply_a(8'h55, "clean");
    chk("clean_data", {28'd0, if_a.out_data}, 32'hB);
    chk("clean_syn", {29'd0, if_a.out_sindrome}, 32'd0);
    chk("clean_flags", {29'd0, if_a.out_error, if_a.out_corregido, if_a.out_doble}, 32'd0);
    @(posedge clk);
    #1 chk("clean_cnt", {16'd0, cnt_simple_a, cnt_doble_a}, 32'd0);
    chk("clean_drained", {31'd0, if_a.out_valid}, 32'd0);

    // Single error at index 4 (position 5)
    apply_a(8'h45, "single");
    chk("single_data", {28'd0, if_a.out_data}, 32'hB);
    chk("single_syn", {29'd0, if_a.out_sindrome}, 32'd5);
    chk("single_flags", {29'd0, if_a.out_error, if_a.out_corregido, if_a.out_doble}, 32'b110);
    chk("single_cnt_before", {24'd0, cnt_simple_a}, 32'd0);
    @(posedge clk);
    #1 chk("single_cnt_after", {24'd0, cnt_simple_a}, 32'd1);

    // Double error at indices 2 and 4
    apply_a(8'h41, "double");
    chk("double_data", {28'd0, if_a.out_data}, 32'h8);
    chk("double_syn", {29'd0, if_a.out_sindrome}, 32'd6);
    chk("double_flags", {29'd0, if_a.out_error, if_a.out_corregido, if_a.out_doble}, 32'b101);
    @(posedge clk);
    #1 chk("double_cnt", {16'd0, cnt_simple_a, cnt_doble_a}, {16'd0, 8'd1, 8'd1});

    // Global parity bit flipped
    apply_a(8'hD5, "parity");
    chk("parity_data", {28'd0, if_a.out_data}, 32'hB);
    chk("parity_syn", {29'd0, if_a.out_sindrome}, 32'd0);
    chk("parity_flags", {29'd0, if_a.out_error, if_a.out_corregido, if_a.out_doble}, 32'b110);
    @(posedge clk);
    #1 chk("parity_cnt", {24'd0, cnt_simple_a}, 32'd2);

    // Backpressure: three words offered with out_ready low
    if_a.out_ready = 1'b0;
    if_a.in_valid  = 1'b1;
    if_a.in_cw     = 8'h55;
    chk("bp_acc1", {31'd0, if_a.in_ready}, 32'd1);
    @(posedge clk);
    #1 if_a.in_cw = 8'h45;
    chk("bp_acc2", {31'd0, if_a.in_ready}, 32'd1);
    @(posedge clk);
    #1 if_a.in_cw = 8'h41;
    @(negedge clk);
    chk("bp_stall", {31'd0, if_a.in_ready}, 32'd0);
    chk("bp_vld", {31'd0, if_a.out_valid}, 32'd1);
    chk("bp_w1", {25'd0, if_a.out_data, if_a.out_sindrome}, {25'd0, 4'hB, 3'd0});
    @(posedge clk);
    @(negedge clk);
    chk("bp_frozen_stall", {31'd0, if_a.in_ready}, 32'd0);
    chk("bp_frozen_w1", {24'd0, if_a.out_valid, if_a.out_data, if_a.out_sindrome},
        {24'd0, 1'b1, 4'hB, 3'd0});
    if_a.out_ready = 1'b1;
    #1 chk("bp_release_rdy", {31'd0, if_a.in_ready}, 32'd1);
    @(posedge clk);
    #1 if_a.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_w2", {22'd0, if_a.out_valid, if_a.out_data, if_a.out_sindrome, if_a.out_corregido, if_a.out_doble},
        {22'd0, 1'b1, 4'hB, 3'd5, 1'b1, 1'b0});
    @(posedge clk);
    @(negedge clk);
    chk("bp_w3", {22'd0, if_a.out_valid, if_a.out_data, if_a.out_sindrome, if_a.out_corregido, if_a.out_doble},
        {22'd0, 1'b1, 4'h8, 3'd6, 1'b0, 1'b1});
    @(posedge clk);
    @(negedge clk);
    chk("bp_empty", {31'd0, if_a.out_valid}, 32'd0);
    @(posedge clk);
    #1 chk("bp_cnt", {16'd0, cnt_simple_a, cnt_doble_a}, {16'd0, 8'd3, 8'd2});

    // Counter clear
    clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    chk("clr_cnt", {16'd0, cnt_simple_a, cnt_doble_a}, 32'd0);

    // Reset while a word sits in S1: it must never appear
    if_a.in_valid = 1'b1;
    if_a.in_cw    = 8'h45;
    @(posedge clk);
    #1 if_a.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("flight_rst_vld", {31'd0, if_a.out_valid}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flight_discard", {31'd0, if_a.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1 chk("flight_cnt", {24'd0, cnt_simple_a}, 32'd0);

    // CNT_W=2 instance: five corrected words saturate at 3
    if_b.in_valid = 1'b1;
    if_b.in_cw    = 8'h45;
    repeat (5) @(posedge clk);
    #1 if_b.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("sat_cnt", {30'd0, cnt_simple_b}, 32'd3);

    // Sixth word leaves in the same cycle clr_cnt is asserted
    if_b.in_valid = 1'b1;
    if_b.in_cw    = 8'h45;
    @(posedge clk);
    #1 if_b.in_valid = 1'b0;
    @(posedge clk);
    #1 clr_b = 1'b1;
    @(negedge clk);
    chk("clr_race_vld", {31'd0, if_b.out_valid & if_b.out_corregido}, 32'd1);
    @(posedge clk);
    #1 clr_b = 1'b0;
    chk("clr_race_cnt", {30'd0, cnt_simple_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
